exonbus_ctrl: RTL

Transfer sequencer for the `exonbus` shared 8-bit tri-state datapath, which holds registers A, B, C and an input port I. It accepts one move command at a time (source, destination, optional immediate byte) over a valid/ready handshake. It emits the bus enables and register loads in a fixed drive → load → release order, so that at most one driver is on `zbus` in any cycle. It sits between the system control logic and the `exonbus` instance, and replaces hand-sequenced enable/load stimulus.

---
 rtl/exonbus_pkg.sv | 41 ++++
 rtl/exonbus_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/exonbus_pkg.sv
// Shared definitions for the exonbus transfer sequencer: source encodings,
// destination bit positions, FSM states and the default datapath width.
package exonbus_pkg;

   localparam int DW_DEF = 8;

   localparam logic [1:0] SRC_I = 2'd0;
   localparam logic [1:0] SRC_A = 2'd1;
   localparam logic [1:0] SRC_B = 2'd2;
   localparam logic [1:0] SRC_C = 2'd3;

   localparam int DST_A = 0;
   localparam int DST_B = 1;
   localparam int DST_C = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LOAD  = 2'd2,
      ST_REL   = 2'd3
   } state_e;

   // Destination-mask bit occupied by a register source; the input port has none.
   function automatic logic [2:0] src_mask(input logic [1:0] src);
      logic [2:0] m;
      m = 3'b000;
      case (src)
         SRC_A:   m[DST_A] = 1'b1;
         SRC_B:   m[DST_B] = 1'b1;
         SRC_C:   m[DST_C] = 1'b1;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   // One-hot driver enable, bit order {enc, enb, ena, eni}.
   function automatic logic [3:0] src_enable(input logic [1:0] src);
      return 4'b0001 << src;
   endfunction

endpackage

// File: rtl/exonbus_ctrl.sv
// Drive -> load -> release sequencer for the exonbus shared datapath.
// Define EXONBUS_MULTI_DST_EN to allow broadcast to several destinations.
module exonbus_ctrl
   import exonbus_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_src,
   input  logic [2:0]    cmd_dst,
   input  logic [DW-1:0] cmd_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          eni,
   output logic          ena,
   output logic          enb,
   output logic          enc,
   output logic          lda,
   output logic          ldb,
   output logic          ldc,
   output logic [DW-1:0] inData
);

   state_e        r_state;
   logic [2:0]    r_dst;
   logic [3:0]    r_en;
   logic [2:0]    r_ld;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [DW-1:0] r_indata;

   logic w_accept;
   logic w_dst_ok;
   logic w_legal;

   assign w_accept = cmd_valid & r_ready;

`ifdef EXONBUS_MULTI_DST_EN
   assign w_dst_ok = 1'b1;
`else
   assign w_dst_ok = ((cmd_dst & (cmd_dst - 3'd1)) == 3'd0);
`endif

   assign w_legal = (cmd_dst != 3'd0)
                 && ((cmd_dst & src_mask(cmd_src)) == 3'd0)
                 && w_dst_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_dst    <= 3'd0;
         r_en     <= 4'd0;
         r_ld     <= 3'd0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_indata <= '0;
      end else begin
         // NOTE: pulses default low here; a later non-blocking assignment in the case overrides it.
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (cmd_src == SRC_I)
                     r_indata <= cmd_data;
                  if (w_legal) begin
                     r_state <= ST_DRIVE;
                     r_dst   <= cmd_dst;
                     r_en    <= src_enable(cmd_src);
                     r_busy  <= 1'b1;
                     r_ready <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_DRIVE: begin
               r_state <= ST_LOAD;
               r_ld    <= r_dst;
            end
            ST_LOAD: begin
               // Release the bus the same cycle the destinations have captured it.
               r_state <= ST_REL;
               r_en    <= 4'd0;
               r_ld    <= 3'd0;
               r_done  <= 1'b1;
            end
            ST_REL: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign eni       = r_en[0];
   assign ena       = r_en[1];
   assign enb       = r_en[2];
   assign enc       = r_en[3];
   assign lda       = r_ld[DST_A];
   assign ldb       = r_ld[DST_B];
   assign ldc       = r_ld[DST_C];
   assign inData    = r_indata;

endmodule
